// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, ALU result-mux selector codes and
// the state encoding of the iterative multiplier.
package cpu_pkg;

  localparam int DATA_WIDTH = 24;

  // ALU result-mux selector codes
  localparam logic [2:0] ALU_SEL_ADD = 3'b000;
  localparam logic [2:0] ALU_SEL_SUB = 3'b001;
  localparam logic [2:0] ALU_SEL_AND = 3'b010;
  localparam logic [2:0] ALU_SEL_OR  = 3'b011;
  localparam logic [2:0] ALU_SEL_MUL = 3'b100;
  localparam logic [2:0] ALU_SEL_XOR = 3'b101;
  localparam logic [2:0] ALU_SEL_SHL = 3'b110;
  localparam logic [2:0] ALU_SEL_SHR = 3'b111;

  // Multiplier state encoding
  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_RUN  = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = MUL_IDLE,
    ST_RUN  = MUL_RUN,
    ST_DONE = MUL_DONE
  } mul_state_e;

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/result bundle between the control unit (master) and the
// sequential multiplier (slave).
interface seq_multiplier_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) ();

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic                 overflow;

  modport master (
    output start, a, b,
    input  busy, done, product, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, overflow
  );

endinterface

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier. One partial-product step per
// clock, fixed WIDTH steps per operation; the result registers only change
// on entry to DONE so downstream muxes never see partial sums.
module seq_multiplier
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  seq_multiplier_if.slave  mul
);

  localparam int             CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

  mul_state_e          state_reg, state_next;
  logic [WIDTH-1:0]    mcand_reg, mcand_next;
  // {carry, hi, lo}: hi accumulates partial sums, lo holds the remaining
  // multiplier bits and fills with low product bits as they shift in.
  logic [2*WIDTH:0]    acc_reg, acc_next;
  logic [CW-1:0]       count_reg, count_next;
  logic [2*WIDTH-1:0]  product_reg, product_next;
  logic                overflow_reg, overflow_next;

  logic [WIDTH-1:0]    addend;
  logic [WIDTH:0]      step_sum;

  // Step adder: add the multiplicand into the upper half when the current
  // multiplier bit is set, keeping the carry so the product stays exact.
  always_comb begin
    addend   = acc_reg[0] ? mcand_reg : '0;
    step_sum = acc_reg[2*WIDTH:WIDTH] + {1'b0, addend};
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_next    = state_reg;
    mcand_next    = mcand_reg;
    acc_next      = acc_reg;
    count_next    = count_reg;
    product_next  = product_reg;
    overflow_next = overflow_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (mul.start) begin
          mcand_next = mul.a;
          acc_next   = {1'b0, {WIDTH{1'b0}}, mul.b};
          count_next = '0;
          state_next = ST_RUN;
        end else if (state_reg == ST_DONE) begin
          state_next = ST_IDLE;
        end
      end

      ST_RUN: begin
        acc_next   = {1'b0, step_sum, acc_reg[WIDTH-1:1]};
        count_next = count_reg + 1'b1;
        if (count_reg == LAST_STEP) begin
          state_next    = ST_DONE;
          product_next  = acc_next[2*WIDTH-1:0];
          overflow_next = |acc_next[2*WIDTH-1:WIDTH];
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      mcand_reg    <= '0;
      acc_reg      <= '0;
      count_reg    <= '0;
      product_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mcand_reg    <= mcand_next;
      acc_reg      <= acc_next;
      count_reg    <= count_next;
      product_reg  <= product_next;
      overflow_reg <= overflow_next;
    end
  end

  assign mul.busy     = (state_reg == ST_RUN);
  assign mul.done     = (state_reg == ST_DONE);
  assign mul.product  = product_reg;
  assign mul.overflow = overflow_reg;

endmodule
